// File: rtl/row_psum_accumulator.sv
// Accumulates NUM_TILES consecutive signed row partial sums into one wide word and
// queues completed words in a small output FIFO. Optional macro: ACC_SATURATE_EN.
module row_psum_accumulator #(
    parameter int PARTIAL_SUM_BW = 24,
    parameter int ACC_BW         = 32,
    parameter int NUM_TILES      = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rstn,
    input  logic                                                 clr,
    input  logic                                                 psum_valid,
    input  logic [PARTIAL_SUM_BW-1:0]                            psum_in,
    output logic                                                 psum_ready,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [ACC_BW-1:0]                                    out_data,
    output logic [((NUM_TILES > 1) ? $clog2(NUM_TILES) : 1)-1:0] tile_cnt,
    output logic [$clog2(FIFO_DEPTH):0]                          fifo_count
`ifdef ACC_SATURATE_EN
    ,
    output logic                                                 sat_flag
`endif
);

    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

    logic [0:0]        state_q, state_d;
    logic [ACC_BW-1:0] acc_q, acc_d;
    logic [TW-1:0]     tile_q, tile_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ACC_BW-1:0] head_q, head_d;
    logic [ACC_BW-1:0] mem [FIFO_DEPTH];

    logic [ACC_BW-1:0] ext;
    logic [ACC_BW-1:0] sum;
    logic [ACC_BW-1:0] push_data;
    logic [PW-1:0]     rd_next;
    logic              full, empty, accept, pop, push;

    assign ext     = ACC_BW'($signed(psum_in));
    assign rd_next = rd_ptr_q + PW'(1);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);

    // Only the sample that would complete a word is stalled; fullness is taken
    // before any same-cycle pop.
    assign psum_ready = !(full && (tile_q == LAST_TILE));
    assign accept     = psum_valid && psum_ready;
    assign pop        = !empty && out_ready;

`ifdef ACC_SATURATE_EN
    logic [ACC_BW:0] wide_sum;
    logic            add_ovf;
    logic            sat_seen_q, sat_seen_d;
    logic            sat_flag_q, sat_flag_d;

    assign wide_sum = {acc_q[ACC_BW-1], acc_q} + {ext[ACC_BW-1], ext};
    assign add_ovf  = wide_sum[ACC_BW] ^ wide_sum[ACC_BW-1];
    assign sum      = !add_ovf          ? wide_sum[ACC_BW-1:0] :
                      wide_sum[ACC_BW]  ? {1'b1, {(ACC_BW-1){1'b0}}} :
                                          {1'b0, {(ACC_BW-1){1'b1}}};
    assign sat_flag = sat_flag_q;
`else
    assign sum = acc_q + ext;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tile_d    = tile_q;
        push      = 1'b0;
        push_data = sum;
`ifdef ACC_SATURATE_EN
        sat_seen_d = sat_seen_q;
        sat_flag_d = 1'b0;
`endif
        if (accept) begin
            if (state_q == IDLE) begin
                if (NUM_TILES == 1) begin
                    push      = 1'b1;
                    push_data = ext;
                end else begin
                    acc_d   = ext;
                    tile_d  = TW'(1);
                    state_d = ACCUM;
`ifdef ACC_SATURATE_EN
                    sat_seen_d = 1'b0;
`endif
                end
            end else if (tile_q == LAST_TILE) begin
                push    = 1'b1;
                acc_d   = '0;
                tile_d  = '0;
                state_d = IDLE;
`ifdef ACC_SATURATE_EN
                sat_flag_d = sat_seen_q || add_ovf;
                sat_seen_d = 1'b0;
`endif
            end else begin
                acc_d  = sum;
                tile_d = tile_q + TW'(1);
`ifdef ACC_SATURATE_EN
                sat_seen_d = sat_seen_q || add_ovf;
`endif
            end
        end

        wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? rd_next : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        // The head register keeps the last popped word once the FIFO drains.
        head_d = head_q;
        if (pop && (count_q > CW'(1))) begin
            head_d = mem[rd_next];
        end else if (push && (empty || (pop && count_q == CW'(1)))) begin
            head_d = push_data;
        end

        if (clr) begin
            state_d  = IDLE;
            acc_d    = '0;
            tile_d   = '0;
            push     = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
`ifdef ACC_SATURATE_EN
            sat_seen_d = 1'b0;
            sat_flag_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            tile_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
`ifdef ACC_SATURATE_EN
            sat_seen_q <= 1'b0;
            sat_flag_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            tile_q   <= tile_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
`ifdef ACC_SATURATE_EN
            sat_seen_q <= sat_seen_d;
            sat_flag_q <= sat_flag_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign out_valid  = !empty;
    assign out_data   = head_q;
    assign tile_cnt   = tile_q;
    assign fifo_count = count_q;

endmodule
